// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared sizing helper and round-robin pick function
package sram_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a registered priority pointer
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int ID_WIDTH = id_w(NUM_REQ);

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_nxt;
    logic [MAX_REQ-1:0]  pick;

    // grant the first requester at or after ptr; the pointer moves just past the winner
    always_comb begin
        pick    = rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ);
        gnt     = pick[NUM_REQ-1:0];
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : ID_WIDTH'(i + 1);
    end

    // priority pointer register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ptr <= '0;
        else       ptr <= ptr_nxt;

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: independent round-robin read/write arbitration onto one SRAM
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_gnt,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]            wr_gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_r_addr,
    output logic [ADDR_WIDTH-1:0]         sram_w_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout
);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (rd_req),
        .gnt  (rd_gnt)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (wr_req),
        .gnt  (wr_gnt)
    );

    // one-hot grants select the winning slices; ungranted ports drive zero
    always_comb begin
        sram_r_addr = '0;
        sram_w_addr = '0;
        sram_din    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sram_r_addr |= rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{rd_gnt[i]}};
            sram_w_addr |= wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{wr_gnt[i]}};
            sram_din    |= wr_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_gnt[i]}};
        end
    end

    assign sram_cs = |rd_gnt | |wr_gnt;
    assign sram_we = |wr_gnt;
    assign rd_data = sram_dout;

    // read grant delayed one cycle to line up with the SRAM read latency
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rd_valid <= '0;
        else       rd_valid <= rd_gnt;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous SRAM instance between NUM_REQ requesters. The SRAM has separate read and write address ports, a single chip select, a write enable and one-cycle read latency.
- Each cycle the block grants at most one write and at most one read. Write and read are arbitrated independently, each round-robin.
- It drives the SRAM control and address pins and routes read data back to the winning requester with a one-hot valid.
- Sits between client engines and the SRAM macro/model.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width (depth 2^ADDR_WIDTH).
- ID_WIDTH, $clog2(NUM_REQ), requester index width (localparam-derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- rd_req  input  NUM_REQ  per-requester read request; held until granted.
- rd_addr  input  NUM_REQ*ADDR_WIDTH  packed read addresses, slice i belongs to requester i.
- rd_gnt  output  NUM_REQ  one-hot read grant, combinational from rd_req and rd_ptr.
- wr_req  input  NUM_REQ  per-requester write request; held until granted.
- wr_addr  input  NUM_REQ*ADDR_WIDTH  packed write addresses.
- wr_data  input  NUM_REQ*DATA_WIDTH  packed write data.
- wr_gnt  output  NUM_REQ  one-hot write grant, combinational.
- rd_valid  output  NUM_REQ  one-hot, registered; marks that rd_data belongs to requester i.
- rd_data  output  DATA_WIDTH  read data, passthrough of sram_dout.
- sram_cs  output  1  chip select to SRAM.
- sram_we  output  1  write enable to SRAM.
- sram_r_addr  output  ADDR_WIDTH  SRAM read address.
- sram_w_addr  output  ADDR_WIDTH  SRAM write address.
- sram_din  output  DATA_WIDTH  SRAM write data.
- sram_dout  input  DATA_WIDTH  SRAM read data (valid one cycle after cs).

Behaviour:
- Reset values:
  - rd_ptr and wr_ptr = 0, so requester 0 has first priority.
  - Read-response pipeline cleared; rd_valid = 0.
  - With no requests, grants = 0, sram_cs = 0, sram_we = 0.
  - Address and data outputs = 0 when their port is not granted.
- Arbitration, evaluated separately for read and write:
  - Scan requesters starting at ptr and wrapping modulo NUM_REQ; grant the first one asserting req.
  - On a grant to index k, ptr <= (k+1) mod NUM_REQ at the next edge.
  - With no request, ptr holds.
- Handshake:
  - A request is consumed in the cycle its gnt is high.
  - A requester may change addr/data, or drop req, only after gnt.
  - A requester holding req continuously is granted within NUM_REQ cycles (starvation bound).
- SRAM drive:
  - sram_cs = |rd_gnt | |wr_gnt.
  - sram_we = |wr_gnt.
  - sram_r_addr = granted rd_addr; sram_w_addr and sram_din = granted write slice.
  - A write-only cycle still performs a dummy read at sram_r_addr; it is ignored because rd_valid is not raised.
- Read return:
  - rd_valid <= rd_gnt, registered one cycle after the grant, aligned with sram_dout.
  - rd_data = sram_dout.
  - No backpressure: the requester must accept rd_data when rd_valid is high.
- Simultaneous read and write to the same address in one cycle:
  - The SRAM forwards din, so the read returns the NEW data.
  - This holds whether the read and write come from the same or different requesters.
- Back-to-back grants to the same requester are allowed if it is the only one requesting; there is one read per cycle at full throughput.
- Reset mid-operation:
  - An outstanding read (granted, rd_valid not yet seen) is dropped; rd_valid stays 0 after rstn releases.
  - The SRAM contents are also cleared by the shared reset.
- Undefined behaviour, which the bench should flag as an assertion: X on rd_req or wr_req.

Decomposition:
- Shared package sram_arb_pkg: no typedefs beyond a localparam helper for ID_WIDTH and a function rr_pick(req, ptr) returning the one-hot grant.
- One natural sub-module: rr_arbiter (NUM_REQ-wide round-robin with registered pointer).
  - Instantiated twice, once for reads and once for writes.
  - Ports: clk, rstn, req, gnt.
- Top level handles muxing, SRAM drive and the rd_valid pipeline.

Test Plan:
- Single write then read: requester 0 writes 0xBEEF to addr 3; the next cycle it reads addr 3. Required: wr_gnt=01 in cycle 0, rd_gnt=01 in cycle 1, rd_valid=01 with rd_data=0xBEEF in cycle 2.
- Round-robin fairness: NUM_REQ=2, both hold rd_req for 6 cycles on addrs 1 and 2. Required: rd_gnt sequence 01,10,01,10,01,10; rd_valid follows one cycle later.
- Concurrent R/W same address: req0 writes 0x1234 to addr 5 while req1 reads addr 5 in the same cycle. Required: sram_cs=1, sram_we=1; next cycle rd_valid=10, rd_data=0x1234.
- Pointer hold: req1 alone reads 3 times back-to-back. Required: rd_gnt=10 every cycle. Then both request: req0 is granted first, because the pointer sits at 0 after the grant to 1.
- Reset mid-read: grant a read in cycle N, assert rstn=0 asynchronously before edge N+1. Required: rd_valid=0 immediately and stays 0 after release; a subsequent read of the same addr returns 0x0000.
- Idle: no requests for 10 cycles. Required: sram_cs=0, sram_we=0, rd_valid=0, pointers unchanged.
